// File: rtl/adder_pkg.sv
// Shared types and constant functions for the multi-operand adder pipeline.
package adder_pkg;

  // Sideband that travels alongside each operand set through the stages.
  typedef struct packed {
    logic sgn;
    logic sat;
    logic vld;
  } side_t;

  // Internal width: enough headroom for the sum of n sign-extended operands.
  function automatic int unsigned int_width(int unsigned w, int unsigned n);
    return w + $clog2(n) + 1;
  endfunction

  // Operand count after one 3:2 compressor level.
  function automatic int unsigned next_cnt(int unsigned n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  // Number of compressor levels needed to reduce n operands to two.
  function automatic int unsigned num_levels(int unsigned n);
    int unsigned c = n;
    int unsigned l = 0;
    while (c > 2) begin
      c = next_cnt(c);
      l++;
    end
    return l;
  endfunction

  // Operand count entering tree level lvl.
  function automatic int unsigned cnt_at(int unsigned n, int unsigned lvl);
    int unsigned c = n;
    for (int unsigned i = 0; i < lvl; i++) c = next_cnt(c);
    return c;
  endfunction

  // First tree level evaluated in pipeline stage s; levels spread evenly.
  function automatic int unsigned first_level(int unsigned levels, int unsigned depth,
                                              int unsigned s);
    return (s * levels) / depth;
  endfunction

  // Signed clamp values, right-aligned in 64 bits.
  function automatic logic [63:0] sat_pos(int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_neg(int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/csa_row.sv
// One row of 3:2 carry-save compressors; carry is returned pre-shifted by one.
module csa_row #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] x,
  input  logic [Width-1:0] y,
  input  logic [Width-1:0] z,
  output logic [Width-1:0] s,
  output logic [Width-1:0] c
);

  // Bitwise full adders; the carry out of the top bit falls off (modular sum).
  always_comb begin
    s = x ^ y ^ z;
    c = {(x[Width-2:0] & y[Width-2:0]) | (x[Width-2:0] & z[Width-2:0]) |
         (y[Width-2:0] & z[Width-2:0]), 1'b0};
  end

endmodule

// File: rtl/d_register.sv
// Enabled register with synchronous flush and asynchronous active-low reset to zero.
module d_register #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  // State update: reset wins, then flush, then load on enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/multi_operand_adder_pipe.sv
// Pipelined N-operand adder: CSA tree spread over _DEPTH stages, final CPA,
// overflow detection and optional saturation in the last stage.
module multi_operand_adder_pipe
  import adder_pkg::*;
#(
  parameter int unsigned _W     = 32,
  parameter int unsigned _N     = 4,
  parameter int unsigned _DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [_N*_W-1:0]  a,
  input  logic              sgn,
  input  logic              sat,
  output logic [_W-1:0]     sum,
  output logic              ovf,
  output logic              out_vld,
  input  logic              out_rdy
);

  localparam int unsigned IW = int_width(_W, _N);
  localparam int unsigned L  = num_levels(_N);
  localparam int unsigned LA = (L > 0) ? L : 1;
  localparam logic [63:0] SatPos64 = sat_pos(_W);
  localparam logic [63:0] SatNeg64 = sat_neg(_W);

  logic          adv;
  logic [IW-1:0] stage_in  [_DEPTH][_N];
  logic [IW-1:0] stage_out [_DEPTH][_N];
  side_t         side_in   [_DEPTH];
  logic [IW-1:0] lvl_in    [LA][_N];
  logic [IW-1:0] lvl_out   [LA][_N];

  // Whole pipeline advances together whenever the output slot is free.
  assign adv    = out_rdy | ~out_vld;
  assign in_rdy = adv;

  // Stage-0 operands extended to the internal width per sgn.
  for (genvar k = 0; k < _N; k++) begin : g_ext
    logic [_W-1:0] op;
    assign op             = a[k*_W +: _W];
    assign stage_in[0][k] = {{(IW - _W){sgn & op[_W-1]}}, op};
  end
  assign side_in[0] = '{sgn: sgn, sat: sat, vld: in_vld & adv};

  // Compressor tree levels.
  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int unsigned Cin  = cnt_at(_N, l);
    localparam int unsigned Grp  = Cin / 3;
    localparam int unsigned Cout = next_cnt(Cin);
    for (genvar g = 0; g < Grp; g++) begin : g_csa
      csa_row #(.Width(IW)) u_csa (
        .x(lvl_in[l][3*g]),
        .y(lvl_in[l][3*g+1]),
        .z(lvl_in[l][3*g+2]),
        .s(lvl_out[l][2*g]),
        .c(lvl_out[l][2*g+1])
      );
    end
    for (genvar r = 0; r < Cin % 3; r++) begin : g_pass
      assign lvl_out[l][2*Grp+r] = lvl_in[l][3*Grp+r];
    end
    for (genvar k = Cout; k < _N; k++) begin : g_zero
      assign lvl_out[l][k] = '0;
    end
  end

  // Map tree levels onto pipeline stages; a stage with no level just forwards.
  for (genvar s = 0; s < _DEPTH; s++) begin : g_stage
    localparam int unsigned Lb = first_level(L, _DEPTH, s);
    localparam int unsigned Le = first_level(L, _DEPTH, s + 1);
    if (Le > Lb) begin : g_tree
      for (genvar k = 0; k < _N; k++) begin : g_k
        assign lvl_in[Lb][k]   = stage_in[s][k];
        assign stage_out[s][k] = lvl_out[Le-1][k];
      end
      for (genvar l = Lb + 1; l < Le; l++) begin : g_chain
        for (genvar k = 0; k < _N; k++) begin : g_k
          assign lvl_in[l][k] = lvl_out[l-1][k];
        end
      end
    end else begin : g_fwd
      for (genvar k = 0; k < _N; k++) begin : g_k
        assign stage_out[s][k] = stage_in[s][k];
      end
    end
  end

  // Inter-stage registers; data loads only for valid sets, valid shifts on adv.
  for (genvar s = 1; s < _DEPTH; s++) begin : g_reg
    logic [_N*IW+1:0] d;
    logic [_N*IW+1:0] q;
    logic             vld_q;
    for (genvar k = 0; k < _N; k++) begin : g_k
      assign d[k*IW +: IW] = stage_out[s-1][k];
      assign stage_in[s][k] = q[k*IW +: IW];
    end
    assign d[_N*IW +: 2] = {side_in[s-1].sgn, side_in[s-1].sat};
    d_register #(.Width(_N*IW+2)) u_data (
      .clk(clk), .rst_n(rst_n), .en(adv & side_in[s-1].vld), .flush(1'b0), .d(d), .q(q)
    );
    d_register #(.Width(1)) u_vld (
      .clk(clk), .rst_n(rst_n), .en(adv), .flush(1'b0), .d(side_in[s-1].vld), .q(vld_q)
    );
    assign side_in[s] = '{sgn: q[_N*IW+1], sat: q[_N*IW], vld: vld_q};
  end

  side_t         fin;
  logic [IW-1:0] total;
  logic [IW-_W:0]   hi_s;
  logic [IW-_W-1:0] hi_u;
  logic          ovf_d;
  logic [_W-1:0] sum_d;
  logic [_W:0]   out_q;

  assign fin = side_in[_DEPTH-1];

  // Final carry-propagate add, range check and clamp.
  always_comb begin
    total = stage_out[_DEPTH-1][0] + stage_out[_DEPTH-1][1];
    hi_s  = total[IW-1:_W-1];
    hi_u  = total[IW-1:_W];
    // Signed fits iff the bits above the sign are all copies of it.
    ovf_d = fin.sgn ? ~((&hi_s) | ~(|hi_s)) : (|hi_u);
    sum_d = total[_W-1:0];
    if (fin.sat && ovf_d) begin
      if (!fin.sgn)        sum_d = '1;
      else if (total[IW-1]) sum_d = SatNeg64[_W-1:0];
      else                 sum_d = SatPos64[_W-1:0];
    end
  end

  d_register #(.Width(_W+1)) u_out (
    .clk(clk), .rst_n(rst_n), .en(adv & fin.vld), .flush(1'b0), .d({ovf_d, sum_d}), .q(out_q)
  );
  d_register #(.Width(1)) u_out_vld (
    .clk(clk), .rst_n(rst_n), .en(adv), .flush(1'b0), .d(fin.vld), .q(out_vld)
  );

  assign sum = out_q[_W-1:0];
  assign ovf = out_q[_W];

endmodule

// File: tb/tb_multi_operand_adder_pipe.sv
// Directed bench for the multi-operand adder pipeline (8-bit, 4 operands, depth 2),
// plus a 16-operand depth-4 instance checked against a scoreboard.
module tb_multi_operand_adder_pipe;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_vld, in_rdy, sgn, sat, out_vld, out_rdy, ovf;
  logic [31:0]  a;
  logic [7:0]   sum;
  logic         w_in_vld, w_in_rdy, w_out_vld, w_out_rdy, w_ovf;
  logic [127:0] w_a;
  logic [7:0]   w_sum;
  int           tests = 0;
  int           fails = 0;

  always #5 clk = ~clk;

  multi_operand_adder_pipe #(._W(8), ._N(4), ._DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .a(a), .sgn(sgn), .sat(sat),
    .sum(sum), .ovf(ovf), .out_vld(out_vld), .out_rdy(out_rdy)
  );

  multi_operand_adder_pipe #(._W(8), ._N(16), ._DEPTH(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_vld(w_in_vld), .in_rdy(w_in_rdy), .a(w_a), .sgn(1'b0),
    .sat(1'b0), .sum(w_sum), .ovf(w_ovf), .out_vld(w_out_vld), .out_rdy(w_out_rdy)
  );

  // Reference result {ovf, sum} for four 8-bit operands.
  function automatic logic [8:0] model4(logic [31:0] av, logic s, logic st);
    int t = 0;
    logic o;
    logic [7:0] r;
    for (int k = 0; k < 4; k++) begin
      if (s) t += int'($signed(av[k*8 +: 8]));
      else   t += int'(av[k*8 +: 8]);
    end
    o = s ? (t > 127 || t < -128) : (t > 255);
    r = t[7:0];
    if (st && o) r = s ? ((t < 0) ? 8'h80 : 8'h7F) : 8'hFF;
    return {o, r};
  endfunction

  // Reference result {ovf, sum} for sixteen unsigned 8-bit operands, wrapping.
  function automatic logic [8:0] model16(logic [127:0] av);
    int t = 0;
    for (int k = 0; k < 16; k++) t += int'(av[k*8 +: 8]);
    return {(t > 255), t[7:0]};
  endfunction

  function automatic logic [31:0] mk(int i);
    return {8'(i * 37 + 5), 8'(i * 11), 8'(8'hF0 ^ 8'(i)), 8'(200 - i * 9)};
  endfunction

  task automatic test_reset();
    in_vld = 0; a = '0; sgn = 0; sat = 0; out_rdy = 0;
    w_in_vld = 0; w_a = '0; w_out_rdy = 0;
    rst_n = 0;
    #3;
    tests++;
    if (out_vld !== 1'b0 || sum !== 8'h00 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got vld=%b sum=%h ovf=%b, expected 0/00/0", out_vld, sum, ovf);
    end
    tests++;
    if (in_rdy !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_rdy: got %b, expected 1", in_rdy);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    #1;
    tests++;
    if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
      fails++;
      $display("FAIL post_reset: got in_rdy=%b out_vld=%b, expected 1/0", in_rdy, out_vld);
    end
  endtask

  typedef struct {
    logic [31:0] av;
    logic        s;
    logic        st;
    logic [7:0]  es;
    logic        eo;
  } vec_t;

  task automatic test_arith();
    vec_t v[10];
    v[0] = '{32'hFFFFFFFF, 1'b0, 1'b0, 8'hFC, 1'b1};
    v[1] = '{32'hFFFFFFFF, 1'b0, 1'b1, 8'hFF, 1'b1};
    v[2] = '{32'h641B0000, 1'b1, 1'b0, 8'h7F, 1'b0};
    v[3] = '{32'h641C0000, 1'b1, 1'b1, 8'h7F, 1'b1};
    v[4] = '{32'h80808080, 1'b1, 1'b1, 8'h80, 1'b1};
    v[5] = '{32'h80808080, 1'b1, 1'b0, 8'h00, 1'b1};
    v[6] = '{32'h01020304, 1'b0, 1'b0, 8'h0A, 1'b0};
    v[7] = '{32'hFFFFFFFF, 1'b1, 1'b1, 8'hFC, 1'b0};
    v[8] = '{32'h80808080, 1'b0, 1'b0, 8'h00, 1'b1};
    v[9] = '{32'h7F7F0100, 1'b1, 1'b0, 8'hFF, 1'b1};
    out_rdy = 1;
    for (int i = 0; i < 10; i++) begin
      a = v[i].av; sgn = v[i].s; sat = v[i].st; in_vld = 1;
      @(posedge clk); #1;
      // Scramble inputs after acceptance: mode bits must travel with the set.
      in_vld = 0; a = ~v[i].av; sgn = ~v[i].s; sat = ~v[i].st;
      tests++;
      if (out_vld !== 1'b0) begin
        fails++;
        $display("FAIL arith_early[%0d]: got out_vld=%b, expected 0", i, out_vld);
      end
      @(posedge clk); #1;
      tests++;
      if (out_vld !== 1'b1 || sum !== v[i].es || ovf !== v[i].eo) begin
        fails++;
        $display("FAIL arith[%0d]: got vld=%b sum=%h ovf=%b, expected 1/%h/%b",
                 i, out_vld, sum, ovf, v[i].es, v[i].eo);
      end
    end
    in_vld = 0; a = '0; sgn = 0; sat = 0;
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_q[$];
    logic [8:0] e;
    out_rdy = 1;
    for (int c = 0; c < 12; c++) begin
      in_vld = (c < 10); a = mk(c); sgn = (c % 3 == 1); sat = (c % 2 == 1);
      if (c < 10) exp_q.push_back(model4(a, sgn, sat));
      @(posedge clk); #1;
      tests++;
      if (c >= 1 && c <= 10) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h000;
        if (out_vld !== 1'b1 || {ovf, sum} !== e) begin
          fails++;
          $display("FAIL b2b[%0d]: got vld=%b ovf/sum=%h, expected 1/%h", c - 1, out_vld,
                   {ovf, sum}, e);
        end
      end else if (out_vld !== 1'b0) begin
        fails++;
        $display("FAIL b2b_idle[%0d]: got out_vld=%b, expected 0", c, out_vld);
      end
    end
    in_vld = 0; sgn = 0; sat = 0;
  endtask

  task automatic test_stall();
    logic [8:0] exp_q[$];
    logic [8:0] first;
    logic [8:0] e;
    logic       accept;
    int         sent = 0;
    int         got = 0;
    out_rdy = 0; sgn = 0; sat = 0;
    for (int i = 0; i < 2; i++) begin
      a = mk(i + 20); in_vld = 1;
      exp_q.push_back(model4(a, 1'b0, 1'b0));
      @(posedge clk); #1;
      sent++;
    end
    first = exp_q[0];
    for (int c = 0; c < 3; c++) begin
      a = mk(sent + 20); in_vld = 1; out_rdy = 0;
      #1;
      tests++;
      if (in_rdy !== 1'b0 || out_vld !== 1'b1 || {ovf, sum} !== first) begin
        fails++;
        $display("FAIL stall_hold[%0d]: got in_rdy=%b vld=%b ovf/sum=%h, expected 0/1/%h",
                 c, in_rdy, out_vld, {ovf, sum}, first);
      end
      @(posedge clk); #1;
    end
    for (int c = 0; c < 20 && got < 6; c++) begin
      out_rdy = 1; in_vld = (sent < 6); a = mk(sent + 20);
      #1;
      accept = in_vld && in_rdy;
      if (accept) exp_q.push_back(model4(a, 1'b0, 1'b0));
      if (out_vld && out_rdy) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h000;
        tests++;
        if ({ovf, sum} !== e) begin
          fails++;
          $display("FAIL stall_drain[%0d]: got ovf/sum=%h, expected %h", got, {ovf, sum}, e);
        end
        got++;
      end
      @(posedge clk); #1;
      if (accept) sent++;
    end
    in_vld = 0;
    tests++;
    if (got != 6) begin
      fails++;
      $display("FAIL stall_count: got %0d results, expected 6", got);
    end
  endtask

  task automatic test_reset_inflight();
    out_rdy = 1; sgn = 0; sat = 0;
    for (int i = 0; i < 2; i++) begin
      a = mk(i + 40); in_vld = 1;
      @(posedge clk); #1;
    end
    in_vld = 0;
    tests++;
    if (out_vld !== 1'b1) begin
      fails++;
      $display("FAIL inflight_pre: got out_vld=%b, expected 1", out_vld);
    end
    #2 rst_n = 0;
    #1;
    tests++;
    if (out_vld !== 1'b0 || sum !== 8'h00 || ovf !== 1'b0 || in_rdy !== 1'b1) begin
      fails++;
      $display("FAIL inflight_async: got vld=%b sum=%h ovf=%b rdy=%b, expected 0/00/0/1",
               out_vld, sum, ovf, in_rdy);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      tests++;
      if (out_vld !== 1'b0) begin
        fails++;
        $display("FAIL inflight_stale[%0d]: got out_vld=%b, expected 0", c, out_vld);
      end
    end
  endtask

  task automatic test_wide_latency();
    logic [8:0] e;
    w_out_rdy = 1; w_in_vld = 1;
    w_a = {$urandom, $urandom, $urandom, $urandom};
    e = model16(w_a);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      w_in_vld = 0;
      tests++;
      if (k < 4 && w_out_vld !== 1'b0) begin
        fails++;
        $display("FAIL wide_lat_early[%0d]: got out_vld=%b, expected 0", k, w_out_vld);
      end else if (k == 4 && (w_out_vld !== 1'b1 || {w_ovf, w_sum} !== e)) begin
        fails++;
        $display("FAIL wide_lat: got vld=%b ovf/sum=%h, expected 1/%h", w_out_vld,
                 {w_ovf, w_sum}, e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wide_random();
    localparam int NSets = 3000;
    logic [8:0] exp_q[$];
    logic [8:0] e;
    logic [8:0] held;
    logic       held_v = 1'b0;
    logic       accept;
    int         sent = 0;
    int         got = 0;
    for (int c = 0; c < 30000 && got < NSets; c++) begin
      w_out_rdy = ($urandom_range(3) != 0);
      w_in_vld  = (sent < NSets) && ($urandom_range(4) != 0);
      w_a = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(7) == 0) w_a = '1;
      #1;
      accept = w_in_vld && w_in_rdy;
      if (accept) exp_q.push_back(model16(w_a));
      if (held_v) begin
        tests++;
        if (w_out_vld !== 1'b1 || {w_ovf, w_sum} !== held) begin
          fails++;
          $display("FAIL wide_stable: got vld=%b ovf/sum=%h, expected 1/%h", w_out_vld,
                   {w_ovf, w_sum}, held);
        end
      end
      if (w_out_vld && w_out_rdy) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h000;
        tests++;
        if ({w_ovf, w_sum} !== e) begin
          fails++;
          $display("FAIL wide_result[%0d]: got ovf/sum=%h, expected %h", got, {w_ovf, w_sum}, e);
        end
        got++;
      end
      held_v = w_out_vld && !w_out_rdy;
      held   = {w_ovf, w_sum};
      @(posedge clk); #1;
      if (accept) sent++;
    end
    w_in_vld = 0;
    tests++;
    if (got != NSets) begin
      fails++;
      $display("FAIL wide_count: got %0d results, expected %0d", got, NSets);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_stall();
    test_reset_inflight();
    test_wide_latency();
    test_wide_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
